// File: rtl/rs_station.sv
// Multi-entry reservation station. Buffers issued instructions, captures pending
// operands from the CDB channels and presents the oldest fully-ready entry to one FU.
// Ports:
//   clk_i, reset_i (sync, active-high), flush_i (drops every entry)
//   alloc_*        issue-side handshake and payload (values, tags, ready bits, op)
//   cdb_*          NUM_CDB broadcast channels, channel c at [c*W +: W]
//   iss_*          FU-side handshake and payload, driven combinationally from state
//   count_o, full_o, empty_o   occupancy status from the registered count
module rs_station #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned OP_W    = 7,
  parameter int unsigned NUM_CDB = 2
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        flush_i,
  input  logic                        alloc_valid_i,
  output logic                        alloc_ready_o,
  input  logic [DATA_W-1:0]           alloc_vj_i,
  input  logic [DATA_W-1:0]           alloc_vk_i,
  input  logic [TAG_W-1:0]            alloc_qj_i,
  input  logic [TAG_W-1:0]            alloc_qk_i,
  input  logic                        alloc_jrdy_i,
  input  logic                        alloc_krdy_i,
  input  logic [TAG_W-1:0]            alloc_tag_i,
  input  logic [OP_W-1:0]             alloc_op_i,
  input  logic [NUM_CDB-1:0]          cdb_valid_i,
  input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag_i,
  input  logic [NUM_CDB*DATA_W-1:0]   cdb_data_i,
  output logic                        iss_valid_o,
  input  logic                        iss_ready_i,
  output logic [DATA_W-1:0]           iss_vj_o,
  output logic [DATA_W-1:0]           iss_vk_o,
  output logic [TAG_W-1:0]            iss_tag_o,
  output logic [OP_W-1:0]             iss_op_o,
  output logic [$clog2(DEPTH):0]      count_o,
  output logic                        full_o,
  output logic                        empty_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  // Control state (reset) and payload state (no reset)
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  jrdy_q, jrdy_d;
  logic [DEPTH-1:0]  krdy_q, krdy_d;
  // older_q[i][j] set means entry j was allocated before entry i
  logic [DEPTH-1:0]  older_q [DEPTH];
  logic [DEPTH-1:0]  older_d [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] vj_q [DEPTH];
  logic [DATA_W-1:0] vj_d [DEPTH];
  logic [DATA_W-1:0] vk_q [DEPTH];
  logic [DATA_W-1:0] vk_d [DEPTH];
  logic [TAG_W-1:0]  qj_q [DEPTH];
  logic [TAG_W-1:0]  qj_d [DEPTH];
  logic [TAG_W-1:0]  qk_q [DEPTH];
  logic [TAG_W-1:0]  qk_d [DEPTH];
  logic [TAG_W-1:0]  tag_q [DEPTH];
  logic [TAG_W-1:0]  tag_d [DEPTH];
  logic [OP_W-1:0]   op_q [DEPTH];
  logic [OP_W-1:0]   op_d [DEPTH];

  logic [DEPTH-1:0]  ready_vec;
  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic [IDX_W-1:0]  alloc_idx;
  logic              alloc_fire;
  logic              iss_fire;
  logic [DATA_W:0]   wake_m;

  // Returns {hit, data}; the lowest matching channel wins
  function automatic logic [DATA_W:0] cdb_match(
    input logic [TAG_W-1:0]          tag,
    input logic [NUM_CDB-1:0]        vld,
    input logic [NUM_CDB*TAG_W-1:0]  tags,
    input logic [NUM_CDB*DATA_W-1:0] data
  );
    logic              hit;
    logic [DATA_W-1:0] d;
    hit = 1'b0;
    d   = '0;
    for (int c = 0; c < int'(NUM_CDB); c++) begin
      if (!hit && vld[c] && (tags[c*TAG_W +: TAG_W] == tag)) begin
        hit = 1'b1;
        d   = data[c*DATA_W +: DATA_W];
      end
    end
    return {hit, d};
  endfunction

  // Status derived from the registered count only
  assign count_o       = count_q;
  assign full_o        = (count_q == CNT_W'(DEPTH));
  assign empty_o       = (count_q == '0);
  assign alloc_ready_o = !full_o;

  assign ready_vec = valid_q & jrdy_q & krdy_q;

  // Oldest ready: a ready entry with no older ready entry (ages form a total order)
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (!sel_found && ready_vec[i] && ((older_q[i] & ready_vec) == '0)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  // Lowest-index free slot
  always_comb begin
    alloc_idx = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_idx = IDX_W'(i);
    end
  end

  assign iss_valid_o = sel_found;
  assign iss_vj_o    = vj_q[sel_idx];
  assign iss_vk_o    = vk_q[sel_idx];
  assign iss_tag_o   = tag_q[sel_idx];
  assign iss_op_o    = op_q[sel_idx];

  assign alloc_fire = alloc_valid_i & alloc_ready_o;
  assign iss_fire   = iss_valid_o & iss_ready_i;

  // Next state: wakeup, dispatch, allocate with bypass; flush overrides all
  always_comb begin
    valid_d = valid_q;
    jrdy_d  = jrdy_q;
    krdy_d  = krdy_q;
    older_d = older_q;
    count_d = count_q;
    vj_d    = vj_q;
    vk_d    = vk_q;
    qj_d    = qj_q;
    qk_d    = qk_q;
    tag_d   = tag_q;
    op_d    = op_q;
    wake_m  = '0;

    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_q[i] && !jrdy_q[i]) begin
        wake_m = cdb_match(qj_q[i], cdb_valid_i, cdb_tag_i, cdb_data_i);
        if (wake_m[DATA_W]) begin
          jrdy_d[i] = 1'b1;
          vj_d[i]   = wake_m[DATA_W-1:0];
        end
      end
      if (valid_q[i] && !krdy_q[i]) begin
        wake_m = cdb_match(qk_q[i], cdb_valid_i, cdb_tag_i, cdb_data_i);
        if (wake_m[DATA_W]) begin
          krdy_d[i] = 1'b1;
          vk_d[i]   = wake_m[DATA_W-1:0];
        end
      end
    end

    if (iss_fire) valid_d[sel_idx] = 1'b0;

    if (alloc_fire) begin
      valid_d[alloc_idx] = 1'b1;
      tag_d[alloc_idx]   = alloc_tag_i;
      op_d[alloc_idx]    = alloc_op_i;
      qj_d[alloc_idx]    = alloc_qj_i;
      qk_d[alloc_idx]    = alloc_qk_i;
      // Every entry already resident is older than the newcomer
      older_d[alloc_idx] = valid_q;
      for (int j = 0; j < int'(DEPTH); j++) older_d[j][alloc_idx] = 1'b0;

      wake_m = cdb_match(alloc_qj_i, cdb_valid_i, cdb_tag_i, cdb_data_i);
      jrdy_d[alloc_idx] = alloc_jrdy_i | wake_m[DATA_W];
      vj_d[alloc_idx]   = alloc_jrdy_i ? alloc_vj_i :
                          (wake_m[DATA_W] ? wake_m[DATA_W-1:0] : alloc_vj_i);

      wake_m = cdb_match(alloc_qk_i, cdb_valid_i, cdb_tag_i, cdb_data_i);
      krdy_d[alloc_idx] = alloc_krdy_i | wake_m[DATA_W];
      vk_d[alloc_idx]   = alloc_krdy_i ? alloc_vk_i :
                          (wake_m[DATA_W] ? wake_m[DATA_W-1:0] : alloc_vk_i);
    end

    count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(iss_fire);

    if (flush_i) begin
      valid_d = '0;
      count_d = '0;
    end
  end

  // Control registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= '0;
      jrdy_q  <= '0;
      krdy_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) older_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      jrdy_q  <= jrdy_d;
      krdy_q  <= krdy_d;
      count_q <= count_d;
      older_q <= older_d;
    end
  end

  // Payload registers, qualified by valid_q
  always_ff @(posedge clk_i) begin
    vj_q  <= vj_d;
    vk_q  <= vk_d;
    qj_q  <= qj_d;
    qk_q  <= qk_d;
    tag_q <= tag_d;
    op_q  <= op_d;
  end

endmodule
